change_dispenser: RTL

- Sits downstream of the coffee vending controller. It consumes that controller's one-cycle serve pulse (cafe) and change flags (t50/t100/t200).
- Drives the brewer with a req/done handshake, then pays out the change one coin at a time to a coin hopper over a 4-phase req/ack handshake.
- Keeps per-denomination coin inventory and reports any change it could not pay.

---
 rtl/change_dispenser.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: runs the brewer handshake after a serve pulse, then pays the
// owed change one coin at a time to a hopper, tracking per-denomination inventory.
module change_dispenser #(
   parameter int INV_W    = 6,
   parameter int INIT_50  = 20,
   parameter int INIT_100 = 20,
   parameter int INIT_200 = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cafe,
   input  logic             t50,
   input  logic             t100,
   input  logic             t200,
   input  logic             brew_done,
   input  logic             hop_ack,
   input  logic             refill,
   input  logic [1:0]       refill_sel,
   input  logic [INV_W-1:0] refill_qty,
   output logic             brew_req,
   output logic             hop_req,
   output logic [1:0]       hop_sel,
   output logic             busy,
   output logic             short_err,
   output logic [2:0]       owed,
   output logic             overrun,
   output logic [INV_W-1:0] inv50,
   output logic [INV_W-1:0] inv100,
   output logic [INV_W-1:0] inv200
);

   typedef enum logic [2:0] {
      IDLE,
      BREW,
      PICK,
      REQ,
      RELEASE
   } state_t;

   localparam logic [INV_W-1:0] INV_MAX = '1;

   state_t           state_reg;
   logic [2:0]       amt_reg;
   logic [1:0]       pick_sel;
   logic [2:0]       coin_val;
   logic [INV_W-1:0] inv_q [3];

   // Index 0/1/2 = 50/100/200; the hopper/refill select code is index + 1.
   for (genvar gi = 0; gi < 3; gi++) begin : g_inv
      localparam int INIT = (gi == 0) ? INIT_50 : (gi == 1) ? INIT_100 : INIT_200;

      logic             take;
      logic             add;
      logic [INV_W:0]   sum;
      logic [INV_W-1:0] inv_reg;

      // PICK never selects an empty denomination, so the subtraction cannot wrap.
      assign take = (state_reg == REQ) && hop_ack && (hop_sel == 2'(gi + 1));
      assign add  = refill && (refill_sel == 2'(gi + 1));
      assign sum  = {1'b0, inv_reg} - {{INV_W{1'b0}}, take}
                  + (add ? {1'b0, refill_qty} : {(INV_W + 1){1'b0}});

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            inv_reg <= INV_W'(INIT);
         end else begin
            inv_reg <= sum[INV_W] ? INV_MAX : sum[INV_W-1:0];
         end
      end

      assign inv_q[gi] = inv_reg;
   end

   assign inv50  = inv_q[0];
   assign inv100 = inv_q[1];
   assign inv200 = inv_q[2];

   // Greedy choice: largest coin that fits the remaining amount and is in stock.
   always_comb begin
      pick_sel = 2'b00;
      if (amt_reg >= 3'd4 && inv_q[2] != '0) begin
         pick_sel = 2'b11;
      end else if (amt_reg >= 3'd2 && inv_q[1] != '0) begin
         pick_sel = 2'b10;
      end else if (inv_q[0] != '0) begin
         pick_sel = 2'b01;
      end
   end

   always_comb begin
      case (hop_sel)
         2'b11:   coin_val = 3'd4;
         2'b10:   coin_val = 3'd2;
         default: coin_val = 3'd1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         amt_reg   <= '0;
         brew_req  <= 1'b0;
         hop_req   <= 1'b0;
         hop_sel   <= 2'b00;
         busy      <= 1'b0;
         short_err <= 1'b0;
         owed      <= '0;
         overrun   <= 1'b0;
      end else begin
         if (cafe && state_reg != IDLE) begin
            overrun <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (cafe) begin
                  amt_reg   <= {t200, t100, t50};
                  short_err <= 1'b0;
                  owed      <= '0;
                  brew_req  <= 1'b1;
                  busy      <= 1'b1;
                  state_reg <= BREW;
               end
            end
            // brew_req is already high on entry, so a stale brew_done is only
            // seen after the request has been visible for a full cycle.
            BREW: begin
               if (brew_done) begin
                  brew_req <= 1'b0;
                  if (amt_reg != '0) begin
                     state_reg <= PICK;
                  end else begin
                     busy      <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            PICK: begin
               if (pick_sel != 2'b00) begin
                  hop_sel   <= pick_sel;
                  hop_req   <= 1'b1;
                  state_reg <= REQ;
               end else begin
                  owed      <= amt_reg;
                  short_err <= 1'b1;
                  amt_reg   <= '0;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            REQ: begin
               if (hop_ack) begin
                  amt_reg   <= amt_reg - coin_val;
                  hop_req   <= 1'b0;
                  state_reg <= RELEASE;
               end
            end
            RELEASE: begin
               if (!hop_ack) begin
                  if (amt_reg != '0) begin
                     state_reg <= PICK;
                  end else begin
                     hop_sel   <= 2'b00;
                     busy      <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
